mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have stall_all, input, 1 bit: global pipeline stall; freezes all divider state.
REQ-004 SHALL have funct, input, 6 bits: operation select; MULT=011000, MULTU=011001, DIV=011010, DIVU=011011, MTHI=010001, MTLO=010011; any other code = no-op.
REQ-005 SHALL have operand_1, input, 32 bits: multiplicand / dividend / move source.
REQ-006 SHALL have operand_2, input, 32 bits: multiplier / divisor.
REQ-007 SHALL have hi, input, 32 bits: current architectural HI value.
REQ-008 SHALL have lo, input, 32 bits: current architectural LO value.
REQ-009 SHALL have done, output, 1 bit: result valid this cycle.
REQ-010 SHALL have result, output, 64 bits: {new HI, new LO}.

Function
REQ-011 MULTU SHALL drive result = unsigned operand_1 * operand_2 (full 64 bits), combinationally, with done=1 in the same cycle.
REQ-012 MULT SHALL drive result = two's-complement signed 64-bit product, combinationally, with done=1.
REQ-013 MTHI SHALL drive result = {operand_1, lo}; MTLO SHALL drive result = {hi, operand_1}; both with done=1.
REQ-014 Any other funct SHALL drive result = {hi, lo} with done=1.
REQ-015 DIV/DIVU SHALL use a radix-2 restoring divider FSM with states IDLE, BUSY and DONE.
REQ-016 In IDLE with a divide funct and stall_all=0, the FSM SHALL latch the operands (absolute values for DIV), clear a 5-bit counter and go to BUSY.
REQ-017 BUSY SHALL produce one quotient bit per cycle; after 32 BUSY cycles the FSM SHALL go to DONE.
REQ-018 done SHALL be 1 only in DONE while a divide funct is presented; done SHALL be 0 in IDLE and BUSY for divide functs.
REQ-019 Divide result SHALL be {remainder, quotient}; for DIV the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-020 In DONE, stall_all=0 SHALL return the FSM to IDLE at the next edge; stall_all=1 SHALL hold DONE and the result.
REQ-021 stall_all=1 in BUSY SHALL freeze the counter and the partial remainder/quotient.
REQ-022 If funct is not DIV/DIVU while in BUSY or DONE, the FSM SHALL abort to IDLE at the next edge, and output SHALL follow the new funct.
REQ-023 A divisor of 0 SHALL skip BUSY, go straight to DONE and yield result = {operand_1, 32'hFFFFFFFF}.
REQ-024 Divide latency SHALL be exactly 33 cycles from the accepting IDLE edge to done=1 with no stalls; each stall cycle adds one.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.

Reset
REQ-026 rst=0 SHALL immediately force the FSM to IDLE and clear the counter and all divider registers, independent of clk.
REQ-027 While rst=0, done SHALL be 0 and result SHALL be 0.
REQ-028 Reset in the middle of a divide SHALL discard the divide; after release, a divide funct SHALL restart from IDLE.

Structure
REQ-029 A shared package SHALL hold the funct code constants, the DATA (32) and DOUBLE_DATA (64) widths, and the FSM state encoding.
REQ-030 The iterative divider SHALL be one sub-module, div_core, with start, stall, signed, operand, done and {rem, quot} ports.
REQ-031 The multiply and move paths SHALL remain combinational in mult_div.

Verification
REQ-032 MULTU 12 x 12 -> done=1 same cycle, result 0x0000000000000090.
REQ-033 MULT 0x80000012 x 0x80000012 -> result 0x3FFFFFEE00000144, done=1.
REQ-034 DIVU 142 / 12 -> done low 33 cycles, then result 0x0000000A0000000B.
REQ-035 DIV 0x80000012 / 0x00000012 -> result 0xFFFFFFFEF8E38E3A after 33 cycles.
REQ-036 DIVU 7 / 0 -> done next cycle, result 0x00000007FFFFFFFF.
REQ-037 Three scenarios, each run separately: stall_all=1 for 5 cycles mid-divide -> done at cycle 38; rst pulse at cycle 10 -> done=0 and restart; funct changed to no-op mid-divide -> result {hi, lo}, done=1.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared widths, funct encodings and divider state encoding for the mult/div unit.
package mult_div_pkg;

    localparam int DATA        = 32;
    localparam int DOUBLE_DATA = 64;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_funct(input logic [5:0] f);
        return (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider, one quotient bit per cycle, output {rem, quot}.
// state   | meaning
// IDLE    | waiting for a divide request; latches |operands| on accept
// BUSY    | shifting out one quotient bit per unstalled cycle
// DONE    | result valid while the divide request is held
module div_core
    import mult_div_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   stall_i,
    input  logic                   signed_i,
    input  logic [DATA-1:0]        dividend_i,
    input  logic [DATA-1:0]        divisor_i,
    output logic                   done_o,
    output logic [DOUBLE_DATA-1:0] rem_quot_o
);

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q;
    logic [DATA-1:0] rem_q, quot_q, dvsr_q;
    logic            qneg_q, rneg_q;

    logic [DATA-1:0] a_abs, b_abs;
    logic [DATA:0]   shifted, diff;
    logic            step_bit;
    logic [DATA-1:0] step_rem;
    logic [DATA-1:0] quot_out, rem_out;

    assign a_abs = (signed_i && dividend_i[DATA-1]) ? -dividend_i : dividend_i;
    assign b_abs = (signed_i && divisor_i[DATA-1])  ? -divisor_i  : divisor_i;

    assign shifted  = {rem_q, quot_q[DATA-1]};
    assign diff     = shifted - {1'b0, dvsr_q};
    assign step_bit = ~diff[DATA];
    assign step_rem = step_bit ? diff[DATA-1:0] : shifted[DATA-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping the divide request aborts from any state, even while stalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stall_i) begin
                    state_d = (divisor_i == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (!stall_i && cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_i || !stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !stall_i) begin
                        cnt_q <= '0;
                        if (divisor_i == '0) begin
                            // Divide-by-zero result is preloaded so DONE needs no special case.
                            rem_q  <= dividend_i;
                            quot_q <= '1;
                            dvsr_q <= '0;
                            qneg_q <= 1'b0;
                            rneg_q <= 1'b0;
                        end else begin
                            rem_q  <= '0;
                            quot_q <= a_abs;
                            dvsr_q <= b_abs;
                            qneg_q <= signed_i && (dividend_i[DATA-1] ^ divisor_i[DATA-1]);
                            rneg_q <= signed_i && dividend_i[DATA-1];
                        end
                    end
                end
                ST_BUSY: begin
                    if (start_i && !stall_i) begin
                        cnt_q  <= cnt_q + 5'd1;
                        rem_q  <= step_rem;
                        quot_q <= {quot_q[DATA-2:0], step_bit};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        quot_out   = qneg_q ? -quot_q : quot_q;
        rem_out    = rneg_q ? -rem_q  : rem_q;
        done_o     = (state_q == ST_DONE) && start_i;
        rem_quot_o = {rem_out, quot_out};
    end

endmodule

// File: rtl/mult_div.sv
// HI/LO unit: combinational multiply and moves, iterative divide via div_core.
module mult_div
    import mult_div_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_all,
    input  logic [5:0]             funct,
    input  logic [DATA-1:0]        operand_1,
    input  logic [DATA-1:0]        operand_2,
    input  logic [DATA-1:0]        hi,
    input  logic [DATA-1:0]        lo,
    output logic                   done,
    output logic [DOUBLE_DATA-1:0] result
);

    logic                          div_req;
    logic                          div_done;
    logic [DOUBLE_DATA-1:0]        div_res;
    logic [DOUBLE_DATA-1:0]        prod_u;
    logic signed [DOUBLE_DATA-1:0] prod_s;

    assign div_req = is_div_funct(funct);
    assign prod_u  = {{DATA{1'b0}}, operand_1} * {{DATA{1'b0}}, operand_2};
    assign prod_s  = $signed(operand_1) * $signed(operand_2);

    div_core u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_req),
        .stall_i    (stall_all),
        .signed_i   (funct == FN_DIV),
        .dividend_i (operand_1),
        .divisor_i  (operand_2),
        .done_o     (div_done),
        .rem_quot_o (div_res)
    );

    always_comb begin
        done   = 1'b1;
        result = {hi, lo};
        case (funct)
            FN_MULTU: result = prod_u;
            FN_MULT:  result = prod_s;
            FN_MTHI:  result = {operand_1, lo};
            FN_MTLO:  result = {hi, operand_1};
            FN_DIV, FN_DIVU: begin
                done   = div_done;
                result = div_res;
            end
            default: ;
        endcase
        if (!rst) begin
            done   = 1'b0;
            result = '0;
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: issued ops push expectations, a monitor pops on done.
module tb_mult_div;
    import mult_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_all;
    logic [5:0]  funct;
    logic [31:0] operand_1, operand_2, hi, lo;
    logic        done;
    logic [63:0] result;

    localparam logic [5:0] FN_NOP  = 6'h00;
    localparam logic [5:0] FN_NOP2 = 6'h3F;

    mult_div dut (
        .clk       (clk),
        .rst       (rst),
        .stall_all (stall_all),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .hi        (hi),
        .lo        (lo),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   issue_cyc = 0;
    bit   armed = 1'b0;

    // Monitor: latency is counted in negedges after the cycle the op was presented.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (armed && done) begin
            if (sb.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL sb_empty got done with result=%h want none", result);
            end else begin
                e = sb.pop_front();
                total = total + 1;
                if (result !== e.res) begin
                    bad = bad + 1;
                    $display("FAIL %s result got=%h want=%h", e.name, result, e.res);
                end
                total = total + 1;
                if (cyc - issue_cyc != e.lat) begin
                    bad = bad + 1;
                    $display("FAIL %s latency got=%0d want=%0d", e.name, cyc - issue_cyc, e.lat);
                end
            end
            armed = 1'b0;
        end else if (armed && (cyc - issue_cyc > 100)) begin
            total = total + 1;
            bad   = bad + 1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("FAIL %s timeout got=no_done want=done_at_%0d", e.name, e.lat);
            end
            armed = 1'b0;
        end
    end

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        funct     = f;
        operand_1 = a;
        operand_2 = b;
        hi        = h;
        lo        = l;
    endtask

    task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input logic [63:0] exp_res, input int lat);
        exp_t e;
        drive(f, a, b, h, l);
        e.res  = exp_res;
        e.lat  = lat;
        e.name = name;
        sb.push_back(e);
        issue_cyc = cyc + 1;
        armed     = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (armed && n < 200) begin
            @(posedge clk);
            n++;
        end
    endtask

    task automatic quiet();
        @(posedge clk);
        #1;
        funct     = FN_NOP;
        stall_all = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                       input logic [63:0] exp_res, input int lat);
        @(posedge clk);
        #1;
        issue(name, f, a, b, h, l, exp_res, lat);
        wait_idle();
        quiet();
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        rst       = 1'b0;
        stall_all = 1'b0;
        drive(FN_NOP, 32'h1234_5678, 32'h9, 32'h1, 32'h2);
        @(negedge clk);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        quiet();

        run("multu_12x12", FN_MULTU, 32'd12, 32'd12, 32'h0, 32'h0, 64'h0000000000000090, 0);
        run("mult_neg_sq", FN_MULT, 32'h80000012, 32'h80000012, 32'h0, 32'h0, 64'h3FFFFFEE00000144, 0);
        run("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 64'hFFFFFFFE00000001, 0);
        run("mult_m1x1", FN_MULT, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 64'hFFFFFFFFFFFFFFFF, 0);
        run("mthi", FN_MTHI, 32'h11111111, 32'h0, 32'h33333333, 32'h22222222, 64'h1111111122222222, 0);
        run("mtlo", FN_MTLO, 32'h11111111, 32'h0, 32'h33333333, 32'h22222222, 64'h3333333311111111, 0);
        run("nop_3f", FN_NOP2, 32'h11111111, 32'h5, 32'hCAFEF00D, 32'hDEADBEEF, 64'hCAFEF00DDEADBEEF, 0);

        run("divu_142_12", FN_DIVU, 32'd142, 32'd12, 32'h0, 32'h0, 64'h0000000A0000000B, 33);
        run("div_neg_18", FN_DIV, 32'h80000012, 32'h00000012, 32'h0, 32'h0, 64'hFFFFFFFEF8E38E3A, 33);
        run("div_min_m1", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 64'h0000000080000000, 33);
        run("div_m7_2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 64'hFFFFFFFFFFFFFFFD, 33);
        run("div_7_m2", FN_DIV, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 64'h00000001FFFFFFFD, 33);
        run("divu_max_1", FN_DIVU, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 64'h00000000FFFFFFFF, 33);
        run("divu_7_0", FN_DIVU, 32'd7, 32'd0, 32'h0, 32'h0, 64'h00000007FFFFFFFF, 1);

        // Stall in BUSY for five cycles stretches latency to 38.
        @(posedge clk);
        #1;
        issue("divu_stall", FN_DIVU, 32'd142, 32'd12, 32'h0, 32'h0, 64'h0000000A0000000B, 38);
        repeat (10) @(posedge clk);
        #1;
        stall_all = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        stall_all = 1'b0;
        wait_idle();
        quiet();

        // Stall in DONE holds done and the result.
        @(posedge clk);
        #1;
        issue("div_zero_hold", FN_DIV, 32'hFFFFFFF0, 32'd0, 32'h0, 32'h0, 64'hFFFFFFF0FFFFFFFF, 1);
        @(posedge clk);
        #1;
        stall_all = 1'b1;
        repeat (3) @(negedge clk);
        check("done_hold_done", {63'b0, done}, 64'd1);
        check("done_hold_result", result, 64'hFFFFFFF0FFFFFFFF);
        quiet();

        // Reset mid-divide discards it; the held divide restarts from IDLE.
        @(posedge clk);
        #1;
        drive(FN_DIVU, 32'd142, 32'd12, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_done", {63'b0, done}, 64'd0);
        check("mid_reset_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue("divu_after_rst", FN_DIVU, 32'd142, 32'd12, 32'h0, 32'h0, 64'h0000000A0000000B, 33);
        wait_idle();
        quiet();

        // Changing funct mid-divide aborts; output follows the new funct.
        @(posedge clk);
        #1;
        drive(FN_DIVU, 32'd142, 32'd12, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        issue("abort_nop", FN_NOP, 32'd142, 32'd12, 32'hAAAA5555, 32'h0F0F0F0F, 64'hAAAA55550F0F0F0F, 0);
        wait_idle();
        @(posedge clk);
        #1;
        issue("divu_after_abort", FN_DIVU, 32'd142, 32'd12, 32'h0, 32'h0, 64'h0000000A0000000B, 33);
        wait_idle();
        quiet();

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
